program_loader: RTL and testbench

Boot-time program loader sitting directly upstream of `memory`. It accepts a byte stream of instructions/data over a valid/ready handshake, writes the bytes sequentially into the 32×8 memory starting at address 0, then reads the region back and compares an 8-bit checksum. It holds the memory ports until it signals `done`; external muxing hands the memory to the CPU afterwards.

---
 rtl/program_loader_if.sv | 21 ++
 rtl/program_loader.sv | 113 +++++++++++
 tb/tb_program_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream source and memory port bundle between the program loader and its neighbours.
// The master modport is the loader's view. The slave modport is the view of the source and memory.
interface program_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       mem_rd;
    logic       mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        output in_ready, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  in_valid, in_data, mem_rdata
    );
    modport slave (
        input  in_ready, mem_rd, mem_wr, mem_addr, mem_wdata,
        output in_valid, in_data, mem_rdata
    );
endinterface

// File: rtl/program_loader.sv
// Streams a byte program into a 32x8 memory, then reads the region back and checks its 8-bit sum.
// The loader owns the memory ports until done rises.
module program_loader #(
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         len,
    program_loader_if.master   bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [7:0]         checksum
);
    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DRAIN, DONE} state_t;

    state_t     state, state_nxt;
    logic [5:0] len_q, wr_ptr, rd_ptr, len_clamp;
    logic [7:0] wsum, rsum, rsum_fin;
    logic       xfer, start_ok;

    assign len_clamp = (len > 6'(DEPTH)) ? 6'(DEPTH) : len;
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign xfer      = (state == WRITE) && bus.in_valid;
    assign rsum_fin  = rsum + bus.mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start_ok) state_nxt = (len_clamp == 6'd0) ? DONE : WRITE;
            WRITE:      if (xfer && wr_ptr == len_q - 6'd1) state_nxt = VERIFY;
            VERIFY:     if (rd_ptr == len_q - 6'd1) state_nxt = DRAIN;
            DRAIN:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Write strobes are combinational so the memory samples them on the same edge as the handshake.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 5'd0;
        bus.mem_wdata = 8'd0;
        busy          = 1'b0;
        unique case (state)
            WRITE: begin
                busy         = 1'b1;
                bus.in_ready = 1'b1;
                if (xfer) begin
                    bus.mem_wr    = 1'b1;
                    bus.mem_addr  = wr_ptr[4:0];
                    bus.mem_wdata = bus.in_data;
                end
            end
            VERIFY: begin
                busy         = 1'b1;
                bus.mem_rd   = 1'b1;
                bus.mem_addr = rd_ptr[4:0];
            end
            DRAIN:   busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wsum     <= '0;
            rsum     <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: if (start_ok) begin
                    len_q  <= len_clamp;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    wsum   <= '0;
                    rsum   <= '0;
                    error  <= 1'b0;
                    done   <= (len_clamp == 6'd0);
                    if (len_clamp == 6'd0) checksum <= '0;
                end
                WRITE: if (xfer) begin
                    wsum   <= wsum + bus.in_data;
                    wr_ptr <= wr_ptr + 6'd1;
                end
                VERIFY: begin
                    // The first read's data only appears in the following cycle.
                    rd_ptr <= rd_ptr + 6'd1;
                    if (rd_ptr != 6'd0) rsum <= rsum_fin;
                end
                DRAIN: begin
                    rsum     <= rsum_fin;
                    done     <= 1'b1;
                    error    <= (wsum != rsum_fin);
                    checksum <= wsum;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader. Stimulus queues the expected memory traffic and results.
// A negedge monitor checks the queued values against what the loader presents.
module tb_program_loader;
    typedef struct {
        logic [7:0] cs;
        logic       err;
        int         lat;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] len;
    logic       busy, done, error;
    logic [7:0] checksum;
    logic       corrupt;
    logic [7:0] mem [32];
    int         cyc = 0, start_cyc = 0;
    int         n_chk = 0, n_pass = 0;

    logic [12:0] wq[$];
    logic [4:0]  rq[$];
    res_t        resq[$];

    program_loader_if bus();

    program_loader #(.DEPTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bus(bus),
        .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory with an optional fault on address 1 reads
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) bus.mem_rdata <= (corrupt && bus.mem_addr == 5'd1) ? 8'h00 : mem[bus.mem_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_wr && bus.mem_rd) chk("rd_wr_exclusive", 1, 0);
            if (bus.mem_wr) begin
                if (wq.size() == 0) chk("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 0);
                else chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, wq.pop_front());
            end
            if (bus.mem_rd) begin
                if (rq.size() == 0) chk("unexpected_read", bus.mem_addr, 0);
                else chk("read_addr", bus.mem_addr, rq.pop_front());
            end
            if (resq.size() > 0 && done) begin
                res_t r;
                r = resq.pop_front();
                chk("checksum", checksum, r.cs);
                chk("error", error, r.err);
                chk("done_latency", cyc - start_cyc, r.lat);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_mem_rd"}, bus.mem_rd, 0);
        chk({tag, "_mem_wr"}, bus.mem_wr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    // Reference: the first min(len,32) bytes land at addresses 0.., the checksum is their sum mod 256, and
    // done arrives 2L+1 edges after start plus one edge per idle source cycle (immediately when L is 0).
    task automatic run_load(input int len_in, input logic [7:0] bq[$], input int sq[$],
                            input bit corr, input int ms, input int abort_at);
        int         l, idle, t;
        logic [7:0] ws, rs;
        bit         ok;
        res_t       r;
        l = (len_in > 32) ? 32 : len_in;
        idle = 0; ws = 0; rs = 0;
        for (int i = 0; i < l; i++) begin
            wq.push_back({i[4:0], bq[i]});
            rq.push_back(i[4:0]);
            ws += bq[i];
            rs += (corr && i == 1) ? 8'h00 : bq[i];
            idle += sq[i];
        end
        corrupt = corr;
        @(posedge clk); #1;
        start = 1'b1; len = len_in[5:0];
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        r.cs = ws; r.err = (ws != rs); r.lat = (l == 0) ? 0 : 2 * l + 1 + idle;
        resq.push_back(r);
        for (int i = 0; i < l; i++) begin
            if (i == abort_at) begin
                #2 rst = 1'b0;
                #1 check_idle_outputs("async_reset");
                wq.delete(); rq.delete(); resq.delete();
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1;
                chk("post_reset_busy", busy, 0);
                chk("post_reset_done", done, 0);
                chk("post_reset_in_ready", bus.in_ready, 0);
                return;
            end
            repeat (sq[i]) begin @(posedge clk); #1; end
            bus.in_valid = 1'b1; bus.in_data = bq[i];
            if (i == ms) begin start = 1'b1; len = 6'd5; end
            t = 0;
            do begin
                @(negedge clk); ok = bus.in_ready;
                @(posedge clk); #1; t++;
                start = 1'b0;
            end while (!ok && t < 50);
            bus.in_valid = 1'b0;
            if (!ok) chk("in_ready_timeout", 0, 1);
        end
        t = 0;
        while (resq.size() > 0 && t < 200) begin @(posedge clk); #1; t++; end
        if (resq.size() > 0) begin chk("done_timeout", 0, 1); resq.delete(); end
        chk("writes_drained", wq.size(), 0);
        chk("reads_drained", rq.size(), 0);
        wq.delete(); rq.delete();
        for (int i = 0; i < l; i++) chk("mem_contents", mem[i], bq[i]);
    endtask

    initial begin
        logic [7:0] bq[$];
        int         sq[$];
        int         rl, ns;
        rst = 1'b0; start = 1'b0; len = '0; corrupt = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        #1 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        bq = '{8'hA5, 8'h3C, 8'h0A}; sq = '{0, 0, 0};
        run_load(3, bq, sq, 0, -1, -1);
        chk("basic_mem01", mem[1], 8'h3C);

        bq = '{8'hFF, 8'h02}; sq = '{0, 1};
        run_load(2, bq, sq, 0, -1, -1);

        bq = '{8'h11, 8'h22}; sq = '{0, 0};
        run_load(2, bq, sq, 1, -1, -1);

        bq.delete(); sq.delete();
        for (int i = 0; i < 32; i++) begin bq.push_back(8'(i)); sq.push_back(0); end
        run_load(40, bq, sq, 0, 10, -1);

        bq.delete(); sq.delete();
        run_load(0, bq, sq, 0, -1, -1);

        bq = '{8'h01, 8'h02, 8'h03, 8'h04}; sq = '{0, 0, 0, 0};
        run_load(4, bq, sq, 0, -1, 2);

        bq = '{8'h7E}; sq = '{0};
        run_load(1, bq, sq, 0, -1, -1);

        for (int k = 0; k < 6; k++) begin
            bq.delete(); sq.delete();
            rl = $urandom_range(0, 40);
            ns = (rl > 32) ? 32 : rl;
            for (int i = 0; i < ns; i++) begin
                bq.push_back(8'($urandom));
                sq.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
            run_load(rl, bq, sq, 0, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
